// File: rtl/pc060ha_pkg.sv
// Shared constants and types for the PC060HA sound-side mailbox port.
package pc060ha_pkg;

    // Data-window index values that are not mailbox nibbles
    localparam logic [2:0] IDX_STATUS  = 3'd4;
    localparam logic [2:0] IDX_NMI_ON  = 3'd5;
    localparam logic [2:0] IDX_NMI_OFF = 3'd6;

    // Mailbox nibbles whose access drives a handshake flag
    localparam logic [2:0] IDX_HS_LO = 3'd1;
    localparam logic [2:0] IDX_HS_HI = 3'd3;

    // Flag bit positions, ordered to match the status nibble {S1, S0, M1, M0}
    localparam int FLAG_M0 = 0;
    localparam int FLAG_M1 = 1;
    localparam int FLAG_S0 = 2;
    localparam int FLAG_S1 = 3;
    localparam int NUM_FLAGS = 4;

    // Strobe capture state: IDLE waits for the strobe to be seen high after reset,
    // ARMED waits for a qualified low phase, ACTIVE holds a captured access.
    typedef enum logic [1:0] {
        CAP_IDLE   = 2'd0,
        CAP_ARMED  = 2'd1,
        CAP_ACTIVE = 2'd2
    } cap_state_e;

    // Auto-increment over the four mailbox nibbles, wrapping 3 -> 0
    function automatic logic [2:0] next_index(input logic [1:0] idx);
        return {1'b0, idx + 2'd1};
    endfunction

endpackage

// File: rtl/pc060ha_mbox_flag.sv
// Single handshake flag: set has priority over clear, async active-low reset.
module pc060ha_mbox_flag (
    input  logic clk,
    input  logic rst_n,
    input  logic set,
    input  logic clr,
    output logic flag
);

    logic flag_q;
    logic flag_d;

    // Next flag value; a simultaneous set wins over a clear
    always_comb begin
        flag_d = flag_q;
        if (set) begin
            flag_d = 1'b1;
        end else if (clr) begin
            flag_d = 1'b0;
        end
    end

    // Flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign flag = flag_q;

endmodule

// File: rtl/pc060ha_sound_port.sv
// Sound-CPU side of the PC060HA mailbox: nibble register interface, handshake
// flags and NMI request towards the sound CPU.
module pc060ha_sound_port
    import pc060ha_pkg::*;
(
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       nCS,
    input  logic       nRD,
    input  logic       nWR,
    input  logic       A0,
    input  logic [3:0] DIN,
    output logic [3:0] DOUT,
    input  logic       M_WR_STB,
    input  logic       M_RD_STB,
    input  logic [1:0] M_IDX,
    input  logic [3:0] M_DIN,
    output logic [3:0] M_DOUT,
    output logic [1:0] M_FLAGS,
    output logic       nNMI
);

    cap_state_e wr_state_q, wr_state_d;
    cap_state_e rd_state_q, rd_state_d;

    logic       wr_a0_q, wr_a0_d;
    logic [3:0] wr_din_q, wr_din_d;
    logic [2:0] wr_idx_q, wr_idx_d;
    logic       rd_a0_q, rd_a0_d;
    logic [2:0] rd_idx_q, rd_idx_d;
    logic       wre;
    logic       rde;

    logic [2:0]      index_q, index_d;
    logic            nmi_en_q, nmi_en_d;
    logic [3:0][3:0] mbox_m_q, mbox_m_d;
    logic [3:0][3:0] mbox_s_q, mbox_s_d;

    logic [NUM_FLAGS-1:0] flag_set;
    logic [NUM_FLAGS-1:0] flag_clr;
    logic [NUM_FLAGS-1:0] flag_q;

    // Write strobe tracker: captures the access every qualified low cycle and
    // fires the write event when nWR rises, whatever nCS does on that cycle
    always_comb begin
        wr_state_d = wr_state_q;
        wr_a0_d    = wr_a0_q;
        wr_din_d   = wr_din_q;
        wr_idx_d   = wr_idx_q;
        wre        = 1'b0;
        case (wr_state_q)
            CAP_IDLE: begin
                if (nWR) begin
                    wr_state_d = CAP_ARMED;
                end
            end
            CAP_ARMED: begin
                if (!nCS && !nWR) begin
                    wr_state_d = CAP_ACTIVE;
                    wr_a0_d    = A0;
                    wr_din_d   = DIN;
                    wr_idx_d   = index_q;
                end
            end
            CAP_ACTIVE: begin
                if (nWR) begin
                    wre        = 1'b1;
                    wr_state_d = CAP_ARMED;
                end else if (!nCS) begin
                    wr_a0_d  = A0;
                    wr_din_d = DIN;
                    wr_idx_d = index_q;
                end else begin
                    wr_state_d = CAP_ARMED;
                end
            end
            default: begin
                wr_state_d = CAP_IDLE;
            end
        endcase
    end

    // Read strobe tracker, same qualification rules as the write side
    always_comb begin
        rd_state_d = rd_state_q;
        rd_a0_d    = rd_a0_q;
        rd_idx_d   = rd_idx_q;
        rde        = 1'b0;
        case (rd_state_q)
            CAP_IDLE: begin
                if (nRD) begin
                    rd_state_d = CAP_ARMED;
                end
            end
            CAP_ARMED: begin
                if (!nCS && !nRD) begin
                    rd_state_d = CAP_ACTIVE;
                    rd_a0_d    = A0;
                    rd_idx_d   = index_q;
                end
            end
            CAP_ACTIVE: begin
                if (nRD) begin
                    rde        = 1'b1;
                    rd_state_d = CAP_ARMED;
                end else if (!nCS) begin
                    rd_a0_d  = A0;
                    rd_idx_d = index_q;
                end else begin
                    rd_state_d = CAP_ARMED;
                end
            end
            default: begin
                rd_state_d = CAP_IDLE;
            end
        endcase
    end

    // Event actions from both CPUs; a sound write overrides a sound read's index update
    always_comb begin
        index_d  = index_q;
        nmi_en_d = nmi_en_q;
        mbox_m_d = mbox_m_q;
        mbox_s_d = mbox_s_q;
        flag_set = '0;
        flag_clr = '0;

        if (rde && rd_a0_q && !rd_idx_q[2]) begin
            index_d = next_index(rd_idx_q[1:0]);
            if (rd_idx_q == IDX_HS_LO) begin
                flag_clr[FLAG_M0] = 1'b1;
            end
            if (rd_idx_q == IDX_HS_HI) begin
                flag_clr[FLAG_M1] = 1'b1;
            end
        end

        if (wre) begin
            if (!wr_a0_q) begin
                index_d = wr_din_q[2:0];
            end else if (!wr_idx_q[2]) begin
                mbox_s_d[wr_idx_q[1:0]] = wr_din_q;
                index_d = next_index(wr_idx_q[1:0]);
                if (wr_idx_q == IDX_HS_LO) begin
                    flag_set[FLAG_S0] = 1'b1;
                end
                if (wr_idx_q == IDX_HS_HI) begin
                    flag_set[FLAG_S1] = 1'b1;
                end
            end else if (wr_idx_q == IDX_NMI_ON) begin
                nmi_en_d = 1'b1;
            end else if (wr_idx_q == IDX_NMI_OFF) begin
                nmi_en_d = 1'b0;
            end
        end

        if (M_WR_STB) begin
            mbox_m_d[M_IDX] = M_DIN;
            if (M_IDX == IDX_HS_LO[1:0]) begin
                flag_set[FLAG_M0] = 1'b1;
            end
            if (M_IDX == IDX_HS_HI[1:0]) begin
                flag_set[FLAG_M1] = 1'b1;
            end
        end

        if (M_RD_STB) begin
            if (M_IDX == IDX_HS_LO[1:0]) begin
                flag_clr[FLAG_S0] = 1'b1;
            end
            if (M_IDX == IDX_HS_HI[1:0]) begin
                flag_clr[FLAG_S1] = 1'b1;
            end
        end
    end

    // Capture trackers, index, NMI enable and mailbox storage
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            wr_state_q <= CAP_IDLE;
            rd_state_q <= CAP_IDLE;
            wr_a0_q    <= 1'b0;
            wr_din_q   <= 4'h0;
            wr_idx_q   <= 3'd0;
            rd_a0_q    <= 1'b0;
            rd_idx_q   <= 3'd0;
            index_q    <= 3'd0;
            nmi_en_q   <= 1'b0;
            mbox_m_q   <= '0;
            mbox_s_q   <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            wr_a0_q    <= wr_a0_d;
            wr_din_q   <= wr_din_d;
            wr_idx_q   <= wr_idx_d;
            rd_a0_q    <= rd_a0_d;
            rd_idx_q   <= rd_idx_d;
            index_q    <= index_d;
            nmi_en_q   <= nmi_en_d;
            mbox_m_q   <= mbox_m_d;
            mbox_s_q   <= mbox_s_d;
        end
    end

    // Handshake flags, one set-priority register each
    for (genvar i = 0; i < NUM_FLAGS; i++) begin : g_flag
        pc060ha_mbox_flag u_flag (
            .clk   (CLK),
            .rst_n (nRESET),
            .set   (flag_set[i]),
            .clr   (flag_clr[i]),
            .flag  (flag_q[i])
        );
    end

    // Sound-CPU read mux: index register, mailbox window or status nibble
    always_comb begin
        DOUT = 4'h0;
        if (!A0) begin
            DOUT = {1'b0, index_q};
        end else if (!index_q[2]) begin
            DOUT = mbox_m_q[index_q[1:0]];
        end else if (index_q == IDX_STATUS) begin
            DOUT = flag_q;
        end
    end

    assign M_DOUT  = mbox_s_q[M_IDX];
    assign M_FLAGS = {flag_q[FLAG_S1], flag_q[FLAG_S0]};
    assign nNMI    = ~(nmi_en_q & (flag_q[FLAG_M0] | flag_q[FLAG_M1]));

endmodule

// File: tb/tb_pc060ha_sound_port.sv
// Directed self-checking bench for the PC060HA sound-side mailbox port.
module tb_pc060ha_sound_port;

    logic       CLK = 1'b0;
    logic       nRESET;
    logic       nCS;
    logic       nRD;
    logic       nWR;
    logic       A0;
    logic [3:0] DIN;
    logic [3:0] DOUT;
    logic       M_WR_STB;
    logic       M_RD_STB;
    logic [1:0] M_IDX;
    logic [3:0] M_DIN;
    logic [3:0] M_DOUT;
    logic [1:0] M_FLAGS;
    logic       nNMI;

    int compareCount = 0;
    int mismatchCount = 0;

    logic [3:0] rdData;
    logic [3:0] peekVal;

    pc060ha_sound_port dut (
        .CLK      (CLK),
        .nRESET   (nRESET),
        .nCS      (nCS),
        .nRD      (nRD),
        .nWR      (nWR),
        .A0       (A0),
        .DIN      (DIN),
        .DOUT     (DOUT),
        .M_WR_STB (M_WR_STB),
        .M_RD_STB (M_RD_STB),
        .M_IDX    (M_IDX),
        .M_DIN    (M_DIN),
        .M_DOUT   (M_DOUT),
        .M_FLAGS  (M_FLAGS),
        .nNMI     (nNMI)
    );

    // Free-running system clock
    always #5 CLK = ~CLK;

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // One complete sound-CPU bus access; returns the data seen while the strobe was low
    task automatic applyStimulus(input logic isWrite, input logic a0, input logic [3:0] din,
                                 output logic [3:0] data);
        A0  = a0;
        DIN = din;
        nCS = 1'b0;
        if (isWrite) nWR = 1'b0;
        else         nRD = 1'b0;
        @(negedge CLK);
        data = DOUT;
        nWR = 1'b1;
        nRD = 1'b1;
        nCS = 1'b1;
        @(negedge CLK);
    endtask

    // Look at DOUT for a given A0 without any strobe
    task automatic peekDout(input logic a0, output logic [3:0] data);
        A0 = a0;
        #1;
        data = DOUT;
    endtask

    // Look at M_DOUT for a given main-side nibble index
    task automatic peekMain(input logic [1:0] idx, output logic [3:0] data);
        M_IDX = idx;
        #1;
        data = M_DOUT;
    endtask

    task automatic mainWrite(input logic [1:0] idx, input logic [3:0] val);
        M_IDX    = idx;
        M_DIN    = val;
        M_WR_STB = 1'b1;
        @(negedge CLK);
        M_WR_STB = 1'b0;
    endtask

    task automatic mainRead(input logic [1:0] idx);
        M_IDX    = idx;
        M_RD_STB = 1'b1;
        @(negedge CLK);
        M_RD_STB = 1'b0;
    endtask

    // Directed scenario sequence
    initial begin
        nRESET   = 1'b0;
        nCS      = 1'b1;
        nRD      = 1'b1;
        nWR      = 1'b1;
        A0       = 1'b0;
        DIN      = 4'h0;
        M_WR_STB = 1'b0;
        M_RD_STB = 1'b0;
        M_IDX    = 2'd0;
        M_DIN    = 4'h0;
        repeat (2) @(negedge CLK);

        // Reset values
        peekDout(1'b0, peekVal);
        checkOutput("reset_index", {4'h0, peekVal}, 8'h00);
        checkOutput("reset_nnmi", {7'h0, nNMI}, 8'h01);
        checkOutput("reset_mflags", {6'h0, M_FLAGS}, 8'h00);
        peekMain(2'd0, peekVal);
        checkOutput("reset_mdout", {4'h0, peekVal}, 8'h00);

        @(negedge CLK);
        nRESET = 1'b1;
        repeat (2) @(negedge CLK);

        // Main writes with NMI disabled
        mainWrite(2'd0, 4'hA);
        mainWrite(2'd1, 4'h5);
        checkOutput("m_write_nnmi", {7'h0, nNMI}, 8'h01);
        applyStimulus(1'b1, 1'b0, 4'h4, rdData);
        peekDout(1'b0, peekVal);
        checkOutput("index_load4", {4'h0, peekVal}, 8'h04);
        peekDout(1'b1, peekVal);
        checkOutput("status_m0", {4'h0, peekVal}, 8'h01);

        // Enable NMI, then read back both mailbox nibbles
        applyStimulus(1'b1, 1'b0, 4'h5, rdData);
        checkOutput("nmi_before_en", {7'h0, nNMI}, 8'h01);
        applyStimulus(1'b1, 1'b1, 4'h0, rdData);
        checkOutput("nmi_on", {7'h0, nNMI}, 8'h00);
        applyStimulus(1'b1, 1'b0, 4'h0, rdData);
        applyStimulus(1'b0, 1'b1, 4'h0, rdData);
        checkOutput("read_nib0", {4'h0, rdData}, 8'h0A);
        checkOutput("nmi_after_nib0", {7'h0, nNMI}, 8'h00);
        applyStimulus(1'b0, 1'b1, 4'h0, rdData);
        checkOutput("read_nib1", {4'h0, rdData}, 8'h05);
        peekDout(1'b0, peekVal);
        checkOutput("index_after_reads", {4'h0, peekVal}, 8'h02);
        checkOutput("nmi_released", {7'h0, nNMI}, 8'h01);

        // Sound writes nibbles 2 and 3, index wraps, SFLAG1 raised then cleared
        applyStimulus(1'b1, 1'b0, 4'h2, rdData);
        applyStimulus(1'b1, 1'b1, 4'h3, rdData);
        checkOutput("mflags_after_s2", {6'h0, M_FLAGS}, 8'h00);
        applyStimulus(1'b1, 1'b1, 4'hC, rdData);
        peekDout(1'b0, peekVal);
        checkOutput("index_wrap", {4'h0, peekVal}, 8'h00);
        checkOutput("mflags_s1", {6'h0, M_FLAGS}, 8'h02);
        peekMain(2'd2, peekVal);
        checkOutput("mbox_s2", {4'h0, peekVal}, 8'h03);
        peekMain(2'd3, peekVal);
        checkOutput("mbox_s3", {4'h0, peekVal}, 8'h0C);
        @(negedge CLK);
        mainRead(2'd3);
        checkOutput("mflags_cleared", {6'h0, M_FLAGS}, 8'h00);

        // Main write to nibble 1 in the same cycle as a sound read event at index 1
        applyStimulus(1'b1, 1'b0, 4'h1, rdData);
        A0  = 1'b1;
        nCS = 1'b0;
        nRD = 1'b0;
        @(negedge CLK);
        rdData   = DOUT;
        nRD      = 1'b1;
        nCS      = 1'b1;
        M_IDX    = 2'd1;
        M_DIN    = 4'h7;
        M_WR_STB = 1'b1;
        @(negedge CLK);
        M_WR_STB = 1'b0;
        checkOutput("simul_old_data", {4'h0, rdData}, 8'h05);
        checkOutput("simul_nnmi", {7'h0, nNMI}, 8'h00);
        peekDout(1'b0, peekVal);
        checkOutput("simul_index", {4'h0, peekVal}, 8'h02);
        applyStimulus(1'b1, 1'b0, 4'h4, rdData);
        peekDout(1'b1, peekVal);
        checkOutput("simul_status", {4'h0, peekVal}, 8'h01);
        applyStimulus(1'b1, 1'b0, 4'h1, rdData);
        peekDout(1'b1, peekVal);
        checkOutput("simul_new_data", {4'h0, peekVal}, 8'h07);

        // Strobes with nCS high are not events
        @(negedge CLK);
        A0  = 1'b0;
        DIN = 4'h6;
        nWR = 1'b0;
        @(negedge CLK);
        nWR = 1'b1;
        @(negedge CLK);
        A0  = 1'b1;
        nRD = 1'b0;
        @(negedge CLK);
        nRD = 1'b1;
        @(negedge CLK);
        peekDout(1'b0, peekVal);
        checkOutput("nocs_index", {4'h0, peekVal}, 8'h01);
        checkOutput("nocs_nnmi", {7'h0, nNMI}, 8'h00);

        // Data write at index 7 changes nothing
        applyStimulus(1'b1, 1'b0, 4'h7, rdData);
        applyStimulus(1'b1, 1'b1, 4'hF, rdData);
        peekDout(1'b0, peekVal);
        checkOutput("idx7_index", {4'h0, peekVal}, 8'h07);
        peekDout(1'b1, peekVal);
        checkOutput("idx7_dout", {4'h0, peekVal}, 8'h00);
        checkOutput("idx7_nnmi", {7'h0, nNMI}, 8'h00);
        checkOutput("idx7_mflags", {6'h0, M_FLAGS}, 8'h00);
        peekMain(2'd0, peekVal);
        checkOutput("idx7_mbox_s0", {4'h0, peekVal}, 8'h00);
        peekMain(2'd3, peekVal);
        checkOutput("idx7_mbox_s3", {4'h0, peekVal}, 8'h0C);

        // Reset asserted in the middle of an index write
        @(negedge CLK);
        A0  = 1'b0;
        DIN = 4'h3;
        nCS = 1'b0;
        nWR = 1'b0;
        @(negedge CLK);
        #1;
        nRESET = 1'b0;
        #1;
        checkOutput("rst_mid_nnmi", {7'h0, nNMI}, 8'h01);
        checkOutput("rst_mid_mflags", {6'h0, M_FLAGS}, 8'h00);
        checkOutput("rst_mid_index", {4'h0, DOUT}, 8'h00);
        peekMain(2'd3, peekVal);
        checkOutput("rst_mid_mdout", {4'h0, peekVal}, 8'h00);
        @(negedge CLK);
        nRESET = 1'b1;
        repeat (2) @(negedge CLK);
        nWR = 1'b1;
        nCS = 1'b1;
        repeat (2) @(negedge CLK);
        peekDout(1'b0, peekVal);
        checkOutput("rst_no_write", {4'h0, peekVal}, 8'h00);
        peekDout(1'b1, peekVal);
        checkOutput("rst_mbox_m0", {4'h0, peekVal}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
